// File: rtl/spike_fetch_encoder_pkg.sv
// Shared types and default sizes for the spike fetch encoder.
// Event stream geometry and run length live here.
package spike_fetch_encoder_pkg;

  localparam int SFE_WIDTH     = 256;
  localparam int SFE_IDX_W     = 8;
  localparam int SFE_ADDR_W    = 16;
  localparam int SFE_NUM_STEPS = 1002;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_LOAD     = 3'd2,
    S_SCAN     = 3'd3,
    S_WAIT_ACK = 3'd4,
    S_DONE     = 3'd5
  } sfe_state_t;

endpackage

// File: rtl/spike_fetch_encoder_prio_enc.sv
// Lowest-set-bit encoder with any/single-bit flags.
// Purely combinational; feeds event index and last flag.
module spike_prio_enc #(
  parameter int WIDTH = 256,
  parameter int IDX_W = 8
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             any,
  output logic             onehot
);

  always_comb begin
    idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDX_W'(i);
    end
  end

  assign any    = |vec;
  // A single set bit survives clearing its lowest set bit as zero.
  assign onehot = any &&
                  ((vec & (vec - WIDTH'(1))) == '0);

endmodule

// File: rtl/spike_fetch_encoder.sv
// Fetches one spike word per timestep and emits one
// address-event per set bit, gated by a step acknowledge.
module spike_fetch_encoder
  import spike_fetch_encoder_pkg::*;
#(
  parameter int WIDTH     = SFE_WIDTH,
  parameter int IDX_W     = SFE_IDX_W,
  parameter int ADDR_W    = SFE_ADDR_W,
  parameter int NUM_STEPS = SFE_NUM_STEPS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  input  logic [WIDTH-1:0]  ram_data,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [IDX_W-1:0]  evt_idx,
  output logic [ADDR_W-1:0] evt_step,
  output logic              evt_last,
  output logic              step_done,
  input  logic              step_ack,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR =
    ADDR_W'(NUM_STEPS - 1);

  sfe_state_t        state, state_n;
  logic [ADDR_W-1:0] addr_n;
  logic [WIDTH-1:0]  shadow, shadow_n;
  logic              done_n;

  logic [IDX_W-1:0]  pe_idx;
  logic              pe_any;
  logic              pe_onehot;

  spike_prio_enc #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_prio (
    .vec    (shadow),
    .idx    (pe_idx),
    .any    (pe_any),
    .onehot (pe_onehot)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      ram_addr <= '0;
      shadow   <= '0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      ram_addr <= addr_n;
      shadow   <= shadow_n;
      done     <= done_n;
    end
  end

  always_comb begin
    state_n  = state;
    addr_n   = ram_addr;
    shadow_n = shadow;
    done_n   = done;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_n = S_FETCH;
          addr_n  = '0;
          done_n  = 1'b0;
        end
      end
      S_FETCH: state_n = S_LOAD;
      S_LOAD: begin
        shadow_n = ram_data;
        state_n  = S_SCAN;
      end
      S_SCAN: begin
        if (!pe_any) begin
          state_n = S_WAIT_ACK;
        end else if (evt_ready) begin
          shadow_n = shadow & ~(WIDTH'(1) << pe_idx);
          if (pe_onehot) state_n = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        if (step_ack) begin
          if (ram_addr == LAST_ADDR) begin
            state_n = S_DONE;
            done_n  = 1'b1;
          end else begin
            addr_n  = ram_addr + ADDR_W'(1);
            state_n = S_FETCH;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign ram_we    = 1'b0;
  assign evt_valid = (state == S_SCAN) && pe_any;
  assign evt_idx   = evt_valid ? pe_idx : '0;
  assign evt_step  = evt_valid ? ram_addr : '0;
  assign evt_last  = evt_valid && pe_onehot;
  assign step_done = (state == S_WAIT_ACK);
  assign busy      = (state != S_IDLE) &&
                     (state != S_DONE);

endmodule

// File: tb/tb_spike_fetch_encoder.sv
// Directed bench for spike_fetch_encoder with a
// 4-step run and a 1-cycle registered RAM model.
module tb_spike_fetch_encoder;

  localparam int W  = 256;
  localparam int IW = 8;
  localparam int AW = 16;
  localparam int NS = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [W-1:0]  ram_data = '0;
  logic          evt_valid;
  logic          evt_ready = 1'b0;
  logic [IW-1:0] evt_idx;
  logic [AW-1:0] evt_step;
  logic          evt_last;
  logic          step_done;
  logic          step_ack = 1'b0;
  logic          busy;
  logic          done;

  logic [W-1:0]  mem [NS];

  int vectors = 0;
  int miscompares = 0;

  spike_fetch_encoder #(
    .WIDTH     (W),
    .IDX_W     (IW),
    .ADDR_W    (AW),
    .NUM_STEPS (NS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_data  (ram_data),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_idx   (evt_idx),
    .evt_step  (evt_step),
    .evt_last  (evt_last),
    .step_done (step_done),
    .step_ack  (step_ack),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ram_data <= mem[ram_addr[1:0]];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    step_ack = 1'b0;
    evt_ready = 1'b0;
    #3;
    rst_n = 1'b1;
    step();
  endtask

  task automatic clr_mem();
    for (int i = 0; i < NS; i++) mem[i] = '0;
  endtask

  initial begin
    clr_mem();
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", evt_valid, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_sdone", step_done, 0);
    chk("rst_we", ram_we, 0);
    rst_n = 1'b1;
    step();

    // three events in one word, ready held high
    mem[0][3] = 1'b1;
    mem[0][7] = 1'b1;
    mem[0][255] = 1'b1;
    evt_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t1_busy", busy, 1);
    chk("t1_fetch_v", evt_valid, 0);
    step();
    chk("t1_load_v", evt_valid, 0);
    step();
    chk("t1_v0", evt_valid, 1);
    chk("t1_i0", evt_idx, 3);
    chk("t1_s0", evt_step, 0);
    chk("t1_l0", evt_last, 0);
    step();
    chk("t1_i1", evt_idx, 7);
    chk("t1_l1", evt_last, 0);
    step();
    chk("t1_i2", evt_idx, 255);
    chk("t1_l2", evt_last, 1);
    step();
    chk("t1_v3", evt_valid, 0);
    chk("t1_sd", step_done, 1);

    // empty timestep
    do_reset();
    clr_mem();
    evt_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    chk("t2_v", evt_valid, 0);
    chk("t2_sd_early", step_done, 0);
    step();
    chk("t2_sd", step_done, 1);
    chk("t2_v2", evt_valid, 0);
    step_ack = 1'b1;
    step();
    step_ack = 1'b0;
    chk("t2_addr", ram_addr, 1);
    chk("t2_sd_off", step_done, 0);
    chk("t2_busy", busy, 1);

    // backpressure; start/ack in SCAN ignored
    do_reset();
    clr_mem();
    mem[0][5] = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    for (int i = 0; i < 4; i++) begin
      chk("t3_v", evt_valid, 1);
      chk("t3_i", evt_idx, 5);
      chk("t3_s", evt_step, 0);
      chk("t3_l", evt_last, 1);
      chk("t3_a", ram_addr, 0);
      start = (i == 1);
      step_ack = (i == 2);
      step();
    end
    start = 1'b0;
    step_ack = 1'b0;
    chk("t3_hold_v", evt_valid, 1);
    chk("t3_hold_a", ram_addr, 0);
    evt_ready = 1'b1;
    step();
    chk("t3_acc_v", evt_valid, 0);
    chk("t3_acc_sd", step_done, 1);

    // full 4-step run
    do_reset();
    for (int i = 0; i < NS; i++) mem[i] = W'(1);
    evt_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int s = 0; s < NS; s++) begin
      step();
      step();
      chk("t4_v", evt_valid, 1);
      chk("t4_i", evt_idx, 0);
      chk("t4_s", evt_step, s);
      chk("t4_l", evt_last, 1);
      step();
      chk("t4_sd", step_done, 1);
      step_ack = 1'b1;
      step();
      step_ack = 1'b0;
    end
    chk("t4_done", done, 1);
    chk("t4_busy", busy, 0);
    chk("t4_addr", ram_addr, 3);
    step();
    step();
    chk("t4_done2", done, 1);
    chk("t4_addr2", ram_addr, 3);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t4_rs_addr", ram_addr, 0);
    chk("t4_rs_done", done, 0);
    chk("t4_rs_busy", busy, 1);

    // reset during SCAN of word 2
    do_reset();
    clr_mem();
    mem[2][10] = 1'b1;
    mem[2][12] = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (evt_valid) break;
      step_ack = step_done;
      step();
    end
    step_ack = 1'b0;
    chk("t5_v", evt_valid, 1);
    chk("t5_i", evt_idx, 10);
    chk("t5_s", evt_step, 2);
    rst_n = 1'b0;
    #1;
    chk("t5_rv", evt_valid, 0);
    chk("t5_ri", evt_idx, 0);
    chk("t5_rs", evt_step, 0);
    chk("t5_ra", ram_addr, 0);
    chk("t5_rb", busy, 0);
    chk("t5_rsd", step_done, 0);
    chk("t5_rd", done, 0);
    #2;
    rst_n = 1'b1;
    step();
    step();
    chk("t5_idle_b", busy, 0);
    chk("t5_idle_v", evt_valid, 0);
    chk("t5_we", ram_we, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
